// File: rtl/apb_uart_pkg.sv
// apb_uart_pkg: shared types and constants for the UART blocks.
// Holds the RX FSM state type, parity codes and framing limits.
package apb_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int MIN_DATA_BITS = 5;
  localparam int DEFAULT_OVS   = 16;

  function automatic logic [3:0] clamp_bits(
    input logic [3:0] bits,
    input logic [3:0] max_bits
  );
    logic [3:0] r;
    r = bits;
    if (bits < 4'(MIN_DATA_BITS)) r = 4'(MIN_DATA_BITS);
    if (bits > max_bits) r = max_bits;
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divisor counter producing one-cycle ticks.
// Counts 0..div-1 while running; div of 0 or 1 ticks every cycle.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 run_i,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;

  assign tick_o = run_i &
    ((div_i <= DIV_WIDTH'(1)) |
     (cnt_q >= div_i - DIV_WIDTH'(1)));

  // Free-run while enabled, restart on clear or when idle
  always_ff @(posedge clk_i) begin
    if (srst_i || clr_i || !run_i) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with valid/ready output.
// Define UART_RX_BREAK_DETECT_EN to add break_o and break handling.
module uart_rx_core
  import apb_uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9,
  parameter int OVS           = DEFAULT_OVS,
  parameter int DIV_WIDTH     = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     en_i,
  input  logic [DIV_WIDTH-1:0]     clk_div_i,
  input  logic [3:0]               data_bits_i,
  input  logic                     parity_en_i,
  input  logic                     parity_type_i,
  input  logic                     stop2_i,
  input  logic                     rx_i,
  output logic [MAX_DATA_BITS-1:0] data_o,
  output logic                     data_valid_o,
  input  logic                     data_ready_i,
  output logic                     parity_error_o,
  output logic                     frame_error_o,
  output logic                     overrun_o,
  output logic                     busy_o
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                     break_o
`endif
);

  localparam int SW = $clog2(OVS);
  localparam logic [SW-1:0] S_LO  = SW'(OVS/2-1);
  localparam logic [SW-1:0] S_MID = SW'(OVS/2);
  localparam logic [SW-1:0] S_HI  = SW'(OVS/2+1);
  localparam logic [SW-1:0] S_END = SW'(OVS-1);

  rx_state_e state_q, state_d;

  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     rx_s, rx_prev_q;
  logic                     start_det, tick;
  logic                     mid_pt, bit_end, maj;
  logic [SW-1:0]            scnt_q;
  logic [1:0]               smp_q;
  logic [3:0]               nbits_q, bit_cnt_q;
  logic                     par_en_q, par_odd_q;
  logic                     stop2_q, stop_cnt_q;
  logic [MAX_DATA_BITS-1:0] sh_q;
  logic                     pe_q, fe_q;
  logic                     done;
`ifdef UART_RX_BREAK_DETECT_EN
  logic                     zero_q;
  logic                     brk;
`endif

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign busy_o    = (state_q != IDLE);
  assign start_det = (state_q == IDLE) & en_i &
                     rx_prev_q & ~rx_s;
  assign mid_pt    = tick & (scnt_q == S_HI);
  assign bit_end   = tick & (scnt_q == S_END);
  assign maj       = (smp_q[0] & smp_q[1]) |
                     (smp_q[0] & rx_s) |
                     (smp_q[1] & rx_s);

  uart_baud_tick #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick (
    .clk_i (clk_i),
    .srst_i(srst_i),
    .run_i (busy_o),
    .clr_i (start_det),
    .div_i (clk_div_i),
    .tick_o(tick)
  );

  // Bring rx into the clock domain; line idles high
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q <= rx_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (srst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; frame completion fires at final stop majority
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    brk     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_det) state_d = START;
      end
      START: begin
        if (mid_pt && maj) state_d = IDLE;
        else if (bit_end)  state_d = DATA;
      end
      DATA: begin
        if (bit_end && bit_cnt_q == nbits_q)
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (mid_pt) begin
`ifdef UART_RX_BREAK_DETECT_EN
          if (!stop_cnt_q && zero_q && !maj) begin
            brk     = 1'b1;
            state_d = WAIT_IDLE;
          end else
`endif
          if (!stop2_q || stop_cnt_q) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (busy_o && !en_i) begin
      state_d = IDLE;
      done    = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      brk     = 1'b0;
`endif
    end
  end

  // Frame datapath: config latch, sampling, shifting, error capture
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      nbits_q    <= 4'(MIN_DATA_BITS);
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      scnt_q     <= '0;
      smp_q      <= 2'b11;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      sh_q       <= '0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      zero_q     <= 1'b0;
`endif
    end else if (start_det) begin
      nbits_q    <= clamp_bits(data_bits_i,
                               4'(MAX_DATA_BITS));
      par_en_q   <= parity_en_i;
      par_odd_q  <= (parity_type_i == PARITY_ODD);
      stop2_q    <= stop2_i;
      scnt_q     <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      sh_q       <= '0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      zero_q     <= 1'b1;
`endif
    end else if (tick) begin
      scnt_q <= (scnt_q == S_END) ? '0 : scnt_q + SW'(1);
      if (scnt_q == S_LO)  smp_q[0] <= rx_s;
      if (scnt_q == S_MID) smp_q[1] <= rx_s;
      if (scnt_q == S_HI) begin
        case (state_q)
          DATA: begin
            sh_q[bit_cnt_q] <= maj;
            bit_cnt_q       <= bit_cnt_q + 4'd1;
`ifdef UART_RX_BREAK_DETECT_EN
            if (maj) zero_q <= 1'b0;
`endif
          end
          PARITY: begin
            if (maj != (^sh_q ^ par_odd_q)) pe_q <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
            if (maj) zero_q <= 1'b0;
`endif
          end
          STOP: begin
            if (!maj) fe_q <= 1'b1;
          end
          default: ;
        endcase
      end
      if (scnt_q == S_END && state_q == STOP)
        stop_cnt_q <= 1'b1;
    end
  end

  // Output register with overrun on a completion into a full slot
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_o         <= '0;
      data_valid_o   <= 1'b0;
      parity_error_o <= 1'b0;
      frame_error_o  <= 1'b0;
      overrun_o      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      break_o        <= 1'b0;
`endif
    end else begin
      overrun_o <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      break_o   <= brk;
`endif
      if (done && (!data_valid_o || data_ready_i)) begin
        data_o         <= sh_q;
        parity_error_o <= pe_q;
        frame_error_o  <= fe_q | ~maj;
        data_valid_o   <= 1'b1;
      end else begin
        if (done)         overrun_o    <= 1'b1;
        if (data_ready_i) data_valid_o <= 1'b0;
      end
    end
  end

endmodule
